// File: rtl/intersection_phase_ctrl.sv
// Four-way intersection phase scheduler: NS/EW car + pedestrian lights, min/max green, latched ped buttons.
// Latency: outputs are registered and change on the clk that carries the timing tick; no backpressure, inputs sampled every clk.
// Optional NIGHT_FLASH_EN adds night_mode and a flashing-yellow FLASH state.
module intersection_phase_ctrl #(
  parameter int TICK_DIV  = 10,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 8,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ns_req,
  input  logic       ew_req,
  input  logic       ns_ped_btn,
  input  logic       ew_ped_btn,
`ifdef NIGHT_FLASH_EN
  input  logic       night_mode,
`endif
  output logic [1:0] ns_car,
  output logic [1:0] ew_car,
  output logic [1:0] ns_hmn,
  output logic [1:0] ew_hmn,
  output logic       ns_ped_pend,
  output logic       ew_ped_pend,
  output logic [6:0] cycle
);
  localparam int PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMAX_A = (GREEN_MAX > YELLOW_T) ? GREEN_MAX : YELLOW_T;
  localparam int TMAX   = (TMAX_A > ALLRED_T) ? TMAX_A : ALLRED_T;
  localparam int TW     = $clog2(TMAX + 1) + 1;

`ifdef NIGHT_FLASH_EN
  typedef enum logic [2:0] {
    INIT_AR, NS_GREEN, NS_YELLOW, AR_NS, EW_GREEN, EW_YELLOW, AR_EW, FLASH
  } state_t;
`else
  typedef enum logic [2:0] {
    INIT_AR, NS_GREEN, NS_YELLOW, AR_NS, EW_GREEN, EW_YELLOW, AR_EW
  } state_t;
`endif

  state_t        state, state_nxt;
  logic [PW-1:0] pre_cnt;
  logic [TW-1:0] timer, timer_nxt, elapsed;
  logic          tick, ns_enter, ew_enter;
  logic          ns_walk, ew_walk, ns_walk_nxt, ew_walk_nxt;
  logic [1:0]    ns_car_nxt, ew_car_nxt, ns_hmn_nxt, ew_hmn_nxt;
`ifdef NIGHT_FLASH_EN
  logic          night_q, night_q_nxt, flash_on, flash_on_nxt;
`endif

  assign tick        = (pre_cnt == PW'(TICK_DIV - 1));
  assign elapsed     = timer + TW'(1);
  assign ns_enter    = (state != NS_GREEN) && (state_nxt == NS_GREEN);
  assign ew_enter    = (state != EW_GREEN) && (state_nxt == EW_GREEN);
  assign ns_walk_nxt = ns_enter ? ns_ped_pend : ns_walk;
  assign ew_walk_nxt = ew_enter ? ew_ped_pend : ew_walk;

  always_comb begin
    state_nxt = state;
    if (tick) begin
      case (state)
        INIT_AR:   if (elapsed >= TW'(ALLRED_T)) state_nxt = NS_GREEN;
        NS_GREEN:  if ((elapsed >= TW'(GREEN_MIN) && (ew_req || ew_ped_pend)) ||
                       elapsed >= TW'(GREEN_MAX)) state_nxt = NS_YELLOW;
        NS_YELLOW: if (elapsed >= TW'(YELLOW_T)) state_nxt = AR_NS;
        AR_NS:     if (elapsed >= TW'(ALLRED_T)) state_nxt = EW_GREEN;
        EW_GREEN:  if ((elapsed >= TW'(GREEN_MIN) && (ns_req || ns_ped_pend)) ||
                       elapsed >= TW'(GREEN_MAX)) state_nxt = EW_YELLOW;
        EW_YELLOW: if (elapsed >= TW'(YELLOW_T)) state_nxt = AR_EW;
        AR_EW:     if (elapsed >= TW'(ALLRED_T)) state_nxt = NS_GREEN;
`ifdef NIGHT_FLASH_EN
        FLASH:     if (!night_mode) state_nxt = INIT_AR;
`endif
        default:   state_nxt = INIT_AR;
      endcase
`ifdef NIGHT_FLASH_EN
      // Night request was captured when the all-red phase began.
      if ((state == AR_NS || state == AR_EW) && state_nxt != state && night_q)
        state_nxt = FLASH;
`endif
    end
  end

  always_comb begin
    if (!tick)                   timer_nxt = timer;
    else if (state_nxt != state) timer_nxt = '0;
    else if (&timer)             timer_nxt = timer;
    else                         timer_nxt = elapsed;
  end

`ifdef NIGHT_FLASH_EN
  always_comb begin
    night_q_nxt = night_q;
    if ((state_nxt == AR_NS || state_nxt == AR_EW) && state_nxt != state)
      night_q_nxt = night_mode;
    if (state_nxt != FLASH)  flash_on_nxt = 1'b0;
    else if (state != FLASH) flash_on_nxt = 1'b1;
    else                     flash_on_nxt = tick ? ~flash_on : flash_on;
  end
`endif

  always_comb begin
    ns_car_nxt = 2'b00;
    ew_car_nxt = 2'b00;
    ns_hmn_nxt = 2'b00;
    ew_hmn_nxt = 2'b00;
    case (state_nxt)
      NS_GREEN: begin
        ns_car_nxt = 2'b10;
        if (ns_walk_nxt) ns_hmn_nxt = (timer_nxt < TW'(WALK_T)) ? 2'b10 : 2'b01;
      end
      NS_YELLOW: ns_car_nxt = 2'b01;
      EW_GREEN: begin
        ew_car_nxt = 2'b10;
        if (ew_walk_nxt) ew_hmn_nxt = (timer_nxt < TW'(WALK_T)) ? 2'b10 : 2'b01;
      end
      EW_YELLOW: ew_car_nxt = 2'b01;
`ifdef NIGHT_FLASH_EN
      FLASH: begin
        ns_car_nxt = {1'b0, flash_on_nxt};
        ew_car_nxt = {1'b0, flash_on_nxt};
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INIT_AR;
      pre_cnt     <= '0;
      timer       <= '0;
      ns_walk     <= 1'b0;
      ew_walk     <= 1'b0;
      ns_car      <= 2'b00;
      ew_car      <= 2'b00;
      ns_hmn      <= 2'b00;
      ew_hmn      <= 2'b00;
      ns_ped_pend <= 1'b0;
      ew_ped_pend <= 1'b0;
      cycle       <= 7'd0;
`ifdef NIGHT_FLASH_EN
      night_q     <= 1'b0;
      flash_on    <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      pre_cnt     <= tick ? '0 : pre_cnt + PW'(1);
      timer       <= timer_nxt;
      ns_walk     <= ns_walk_nxt;
      ew_walk     <= ew_walk_nxt;
      ns_car      <= ns_car_nxt;
      ew_car      <= ew_car_nxt;
      ns_hmn      <= ns_hmn_nxt;
      ew_hmn      <= ew_hmn_nxt;
      // A press coinciding with the green-entry clear keeps the request.
      ns_ped_pend <= ns_ped_btn | (ns_ped_pend & ~ns_enter);
      ew_ped_pend <= ew_ped_btn | (ew_ped_pend & ~ew_enter);
      cycle       <= cycle + 7'(ns_enter);
`ifdef NIGHT_FLASH_EN
      night_q     <= night_q_nxt;
      flash_on    <= flash_on_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_intersection_phase_ctrl.sv
// Self-checking bench for intersection_phase_ctrl against a phase-list reference model.
module tb_intersection_phase_ctrl;
  localparam int TICK_DIV = 2, GREEN_MIN = 4, GREEN_MAX = 8, YELLOW_T = 2, ALLRED_T = 1, WALK_T = 3;
  localparam int PH_INIT = -1, PH_FLASH = 6;
  localparam int PERIOD_CLK = 2 * TICK_DIV * (GREEN_MAX + YELLOW_T + ALLRED_T);

  logic clk = 1'b0, rst_n = 1'b0;
  logic ns_req = 1'b0, ew_req = 1'b0, ns_ped_btn = 1'b0, ew_ped_btn = 1'b0, night_mode = 1'b0;
  logic [1:0] ns_car, ew_car, ns_hmn, ew_hmn;
  logic ns_ped_pend, ew_ped_pend;
  logic [6:0] cycle;
  logic [16:0] dut_vec;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  intersection_phase_ctrl #(
    .TICK_DIV(TICK_DIV), .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX),
    .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T), .WALK_T(WALK_T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ns_req(ns_req), .ew_req(ew_req),
    .ns_ped_btn(ns_ped_btn), .ew_ped_btn(ew_ped_btn),
`ifdef NIGHT_FLASH_EN
    .night_mode(night_mode),
`endif
    .ns_car(ns_car), .ew_car(ew_car), .ns_hmn(ns_hmn), .ew_hmn(ew_hmn),
    .ns_ped_pend(ns_ped_pend), .ew_ped_pend(ew_ped_pend), .cycle(cycle)
  );

  assign dut_vec = {ns_car, ew_car, ns_hmn, ew_hmn, ns_ped_pend, ew_ped_pend, cycle};

  // Safety monitor: never both directions non-red, never code 11.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ((ns_car != 2'b00 && ew_car != 2'b00 && !(ns_car == 2'b01 && ew_car == 2'b01 && night_mode)) ||
          ns_car == 2'b11 || ew_car == 2'b11 || ns_hmn == 2'b11 || ew_hmn == 2'b11) begin
        errors++;
        $display("FAIL safety ns_car=%b ew_car=%b ns_hmn=%b ew_hmn=%b", ns_car, ew_car, ns_hmn, ew_hmn);
      end
    end
  end

  // Reference model: phases 0..5 = NS green/yellow/allred, EW green/yellow/allred.
  int m_pre, m_ph, m_t, m_cycle;
  bit [1:0] m_pend, m_walk, m_clr;
  bit m_night, m_flash;

  task automatic model_reset();
    m_pre = 0; m_ph = PH_INIT; m_t = 0; m_cycle = 0;
    m_pend = 0; m_walk = 0; m_clr = 0; m_night = 0; m_flash = 0;
  endtask

  task automatic model_enter(input int p, input bit [1:0] op);
    m_ph = p; m_t = 0;
    if (p >= 0 && p < 6) begin
      if (p % 3 == 0) begin
        m_walk[p / 3] = op[p / 3];
        m_clr[p / 3] = 1'b1;
        if (p == 0) m_cycle = (m_cycle + 1) % 128;
      end
      if (p % 3 == 2) m_night = night_mode;
    end
    if (p == PH_FLASH) m_flash = 1'b1;
  endtask

  task automatic model_advance();
    bit [1:0] op = m_pend;
    bit [1:0] reqs = {ew_req, ns_req};
    bit [1:0] btn = {ew_ped_btn, ns_ped_btn};
    int o;
    m_clr = 0;
    if (m_pre == TICK_DIV - 1) begin
      m_pre = 0;
      m_t++;
      if (m_ph == PH_INIT) begin
        if (m_t >= ALLRED_T) model_enter(0, op);
      end else if (m_ph == PH_FLASH) begin
        m_flash = !m_flash;
        if (!night_mode) model_enter(PH_INIT, op);
      end else begin
        o = (m_ph < 3) ? 1 : 0;
        case (m_ph % 3)
          0: if ((m_t >= GREEN_MIN && (reqs[o] || op[o])) || m_t >= GREEN_MAX) model_enter(m_ph + 1, op);
          1: if (m_t >= YELLOW_T) model_enter(m_ph + 1, op);
          default: if (m_t >= ALLRED_T) model_enter(m_night ? PH_FLASH : (m_ph + 1) % 6, op);
        endcase
      end
    end else begin
      m_pre++;
    end
    m_pend = btn | (op & ~m_clr);
  endtask

  function automatic logic [16:0] exp_vec();
    logic [1:0] car [2];
    logic [1:0] hmn [2];
    for (int d = 0; d < 2; d++) begin
      car[d] = 2'b00; hmn[d] = 2'b00;
      if (m_ph == PH_FLASH) car[d] = {1'b0, m_flash};
      else if (m_ph >= 0 && m_ph / 3 == d) begin
        if (m_ph % 3 == 0) begin
          car[d] = 2'b10;
          if (m_walk[d]) hmn[d] = (m_t < WALK_T) ? 2'b10 : 2'b01;
        end else if (m_ph % 3 == 1) car[d] = 2'b01;
      end
    end
    return {car[0], car[1], hmn[0], hmn[1], m_pend[0], m_pend[1], 7'(m_cycle)};
  endfunction

  task automatic step();
    model_advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ns_req = 0; ew_req = 0; ns_ped_btn = 0; ew_ped_btn = 0; night_mode = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (dut_vec !== 17'd0) begin errors++; $display("FAIL reset_state got %h exp %h", dut_vec, 17'd0); end
    rst_n = 1'b1;
    for (int i = 1; i <= 2 * TICK_DIV * ALLRED_T; i++) step();
    checks++;
    if (ns_car !== 2'b10 || cycle !== 7'd1) begin
      errors++; $display("FAIL first_green ns_car=%b cycle=%0d exp 10/1", ns_car, cycle);
    end
  endtask

  task automatic test_no_demand();
    int first_ew = -1;
    do_reset();
    for (int i = 1; i <= 60; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL no_demand step %0d got %h exp %h", i, dut_vec, exp_vec()); end
      if (first_ew < 0 && ew_car == 2'b10) first_ew = i;
    end
    checks++;
    if (first_ew != TICK_DIV * (2 * ALLRED_T + GREEN_MAX + YELLOW_T)) begin
      errors++; $display("FAIL no_demand_ew_start got %0d exp %0d", first_ew, TICK_DIV * (2 * ALLRED_T + GREEN_MAX + YELLOW_T));
    end
  endtask

  task automatic test_ew_req();
    int first_y = -1, first_ew = -1;
    do_reset();
    ew_req = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL ew_req step %0d got %h exp %h", i, dut_vec, exp_vec()); end
      if (first_y < 0 && ns_car == 2'b01) first_y = i;
      if (first_ew < 0 && ew_car == 2'b10) first_ew = i;
    end
    checks++;
    if (first_y != TICK_DIV * (ALLRED_T + GREEN_MIN)) begin
      errors++; $display("FAIL ew_req_min_green got %0d exp %0d", first_y, TICK_DIV * (ALLRED_T + GREEN_MIN));
    end
    checks++;
    if (first_ew != first_y + TICK_DIV * (YELLOW_T + ALLRED_T)) begin
      errors++; $display("FAIL ew_req_ew_start got %0d exp %0d", first_ew, first_y + TICK_DIV * (YELLOW_T + ALLRED_T));
    end
  endtask

  task automatic test_ped();
    int walk = 0, flash = 0, guard = 0;
    do_reset();
    while (m_ph != 3 && guard < 200) begin step(); guard++; end
    checks++;
    if (ew_car !== 2'b10) begin errors++; $display("FAIL ped_reach_ew ew_car=%b exp 10", ew_car); end
    ns_ped_btn = 1'b1;
    step();
    ns_ped_btn = 1'b0;
    checks++;
    if (ns_ped_pend !== 1'b1) begin errors++; $display("FAIL ped_latch got %b exp 1", ns_ped_pend); end
    for (int i = 1; i <= 60; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL ped step %0d got %h exp %h", i, dut_vec, exp_vec()); end
      if (ns_hmn == 2'b10) walk++;
      if (ns_hmn == 2'b01) flash++;
    end
    checks++;
    if (walk != TICK_DIV * WALK_T || flash != TICK_DIV * (GREEN_MAX - WALK_T)) begin
      errors++; $display("FAIL ped_walk walk=%0d flash=%0d exp %0d/%0d", walk, flash, TICK_DIV * WALK_T, TICK_DIV * (GREEN_MAX - WALK_T));
    end
  endtask

  task automatic test_cycle_count();
    int n = 0;
    bit seen127 = 0, wrapped = 0;
    do_reset();
    while (cycle != 7'd25 && n < 1500) begin
      step(); n++;
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL cycle25 step %0d got %h exp %h", n, dut_vec, exp_vec()); end
    end
    checks++;
    if (n != TICK_DIV * ALLRED_T + 24 * PERIOD_CLK) begin
      errors++; $display("FAIL cycle25_time got %0d exp %0d", n, TICK_DIV * ALLRED_T + 24 * PERIOD_CLK);
    end
    for (int i = 0; i < 104 * PERIOD_CLK && !wrapped; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL wrap step %0d got %h exp %h", i, dut_vec, exp_vec()); end
      if (cycle == 7'd127) seen127 = 1;
      if (seen127 && cycle == 7'd0) wrapped = 1;
    end
    checks++;
    if (!wrapped) begin errors++; $display("FAIL cycle_wrap got cycle=%0d exp wrap to 0", cycle); end
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    do_reset();
    ew_req = 1'b1;
    while (m_ph != 4 && guard < 200) begin step(); guard++; end
    step();
    checks++;
    if (ew_car !== 2'b01) begin errors++; $display("FAIL mid_reset_setup ew_car=%b exp 01", ew_car); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec !== 17'd0) begin errors++; $display("FAIL async_reset got %h exp %h", dut_vec, 17'd0); end
    model_reset();
    ew_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL restart step %0d got %h exp %h", i, dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 1; i <= 3000; i++) begin
      ns_req = ($urandom_range(3) == 0);
      ew_req = ($urandom_range(3) == 0);
      ns_ped_btn = ($urandom_range(15) == 0);
      ew_ped_btn = ($urandom_range(15) == 0);
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL random step %0d got %h exp %h", i, dut_vec, exp_vec()); end
    end
    ns_req = 0; ew_req = 0; ns_ped_btn = 0; ew_ped_btn = 0;
  endtask

`ifdef NIGHT_FLASH_EN
  task automatic test_night();
    int toggles = 0;
    logic [6:0] c0;
    do_reset();
    step(); step(); step();
    night_mode = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL night step %0d got %h exp %h", i, dut_vec, exp_vec()); end
      if (ns_car == 2'b01 && ew_car == 2'b01) toggles++;
    end
    checks++;
    if (toggles == 0) begin errors++; $display("FAIL night_flash got 0 flash clocks exp >0"); end
    c0 = cycle;
    night_mode = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL night_exit step %0d got %h exp %h", i, dut_vec, exp_vec()); end
    end
    checks++;
    if (cycle !== c0 + 7'd1) begin errors++; $display("FAIL night_cycle got %0d exp %0d", cycle, c0 + 7'd1); end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_no_demand();
    test_ew_req();
    test_ped();
    test_mid_reset();
    test_random();
`ifdef NIGHT_FLASH_EN
    test_night();
`endif
    test_cycle_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/intersection_phase_ctrl.md
Name: intersection_phase_ctrl

Overview:
Central phase scheduler for one four-way intersection. It drives the north-south (NS) and east-west (EW) vehicle and pedestrian light pairs that the per-direction light blocks currently generate independently. It arbitrates right-of-way between the two directions using vehicle-detector requests and latched pedestrian buttons, with minimum and maximum green times. It also exports a 7-bit phase-cycle count for bench monitoring.

Parameters:
TICK_DIV, 10, clk cycles per timing tick (>=1)
GREEN_MIN, 4, min green ticks before demand-driven switch (>=1)
GREEN_MAX, 8, green ticks after which switch is forced (>=GREEN_MIN)
YELLOW_T, 2, yellow ticks (>=1)
ALLRED_T, 1, all-red clearance ticks (>=1)
WALK_T, 3, WALK ticks at start of a served green (<=GREEN_MIN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ns_req  in  1  NS vehicle detector, level
ew_req  in  1  EW vehicle detector, level
ns_ped_btn  in  1  NS pedestrian button, 1-clk pulse or level
ew_ped_btn  in  1  EW pedestrian button
ns_car  out  2  NS vehicle light: 00 RED, 01 YELLOW, 10 GREEN
ew_car  out  2  EW vehicle light, same encoding
ns_hmn  out  2  NS pedestrian: 00 STOP, 01 FLASH, 10 WALK
ew_hmn  out  2  EW pedestrian, same encoding
ns_ped_pend  out  1  NS pedestrian request latched
ew_ped_pend  out  1  EW pedestrian request latched
cycle  out  7  count of NS_GREEN entries, wraps 127->0

Behaviour:
- Reset (async, rst_n=0): state INIT_AR; both car lights 00; both hmn lights 00; pend=0; cycle=0; prescaler=0; phase timer=0.
- Prescaler counts 0..TICK_DIV-1; tick=1 on terminal count. Phase timers and state transitions advance only on tick. TICK_DIV=1 gives tick every clk.
- Transitions (all on tick). Phase timer clears on each state entry.
  - INIT_AR -> NS_GREEN after ALLRED_T ticks.
  - NS_GREEN -> NS_YELLOW when (timer>=GREEN_MIN and (ew_req or ew_ped_pend)) or timer==GREEN_MAX.
  - NS_YELLOW -> AR_NS after YELLOW_T ticks; AR_NS -> EW_GREEN after ALLRED_T ticks.
  - EW_GREEN, EW_YELLOW and AR_EW are symmetric; AR_EW -> NS_GREEN.
- Outputs are registered and reflect the current state:
  - Direction in GREEN: car=10. In YELLOW: car=01. All other states: car=00.
- Pedestrian lights:
  - On entry to a direction's GREEN, that direction's pend is sampled into walk_served, and pend is cleared.
  - If walk_served: hmn=10 for the first WALK_T ticks of GREEN, then 01 for the rest of GREEN.
  - If not served: hmn=00.
  - hmn=00 in every non-GREEN state.
- pend latching: pend sets the clk after a button is seen high; it clears only on entry to its own GREEN. A press in the same clk as the clear leaves pend=1 (set wins).
- cycle increments by 1 on every entry to NS_GREEN, including the first after reset. Wraps 127->0 mod 2^7.
- Safety invariant: ns_car and ew_car are never both non-RED in any clk. The value 11 never appears on any light output.
- Reset mid-phase: immediate return to reset values, regardless of state or prescaler.

Optional Feature:
NIGHT_FLASH_EN
- Defined: adds input night_mode (1 bit).
  - When night_mode=1 at entry to AR_NS or AR_EW, the next state is FLASH instead of the next green.
  - In FLASH: both car lights toggle 01/00 on each tick, starting at 01; hmn=00; pend keeps latching; cycle holds.
  - When night_mode=0 at a tick: FLASH -> INIT_AR, then the normal sequence resumes with NS_GREEN.
- Undefined: no port, no FLASH state; behaviour exactly as above.

Test Plan:
Parameters for all scenarios: TICK_DIV=2, GREEN_MIN=4, GREEN_MAX=8, YELLOW_T=2, ALLRED_T=1, WALK_T=3.
1. Reset, no demand -> car 00/00 for 1 tick, then NS_GREEN for 8 ticks (16 clk), NS yellow 4 clk, all-red 2 clk, EW green 16 clk. cycle=1 after first NS_GREEN entry.
2. ew_req held high from reset -> NS green lasts exactly 4 ticks (8 clk) before NS yellow. ew_car=10 begins 3 ticks later.
3. ns_ped_btn pulse during EW_GREEN -> ns_ped_pend=1 next clk. At NS_GREEN entry: ns_hmn=10 for 6 clk, then 01 until NS_YELLOW, then 00; ns_ped_pend=0.
4. No demand, run until cycle==25 -> reached 529 ticks after first tick post-reset (22-tick period). ns/ew lights never both non-00 at any clk (checked every clk by assertion).
5. rst_n pulled low mid EW_YELLOW -> all outputs return to 00 and cycle=0 in the same clk, asynchronously. Sequence restarts from INIT_AR after release.
6. With NIGHT_FLASH_EN: night_mode=1 during NS_GREEN -> after AR_NS, both car lights toggle 01/00 every tick. Deasserting night_mode -> INIT_AR, then NS_GREEN with cycle incremented.
